// File: rtl/id_ex_pipe.sv
// id_ex_pipe: RV32I decode stage with a built-in ID/EX pipeline register.
// Decodes inst_i into ALU operands (op1/op2) and branch-adder operands
// (op1_jump/op2_jump), forwards write-back data onto rs1/rs2, and registers
// the result behind a valid/ready handshake. Includes a load-use interlock,
// a jump flush, illegal-opcode flagging and a saturating stall counter.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   inst_*_i / id_ready_o     upstream handshake from IF/ID
//   regr*_addr_o, reg*_rdata_i, csrr_addr_o, csr_rdata_i  register/CSR reads
//   wb_regw_*_i               write-back port, used for forwarding
//   ex_jump_flag_i            taken jump in EX, flushes this stage
//   ex_ready_i / ex_valid_o   downstream handshake to EX
//   remaining *_o             registered decode results, stall_cnt_o
module id_ex_pipe #(
  parameter int          XLEN     = 32,
  parameter int          CSR_AW   = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter bit          FWD_EN   = 1'b1,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  input  logic              inst_valid_i,
  output logic              id_ready_o,
  output logic [4:0]        regr1_addr_o,
  output logic [4:0]        regr2_addr_o,
  input  logic [XLEN-1:0]   reg1_rdata_i,
  input  logic [XLEN-1:0]   reg2_rdata_i,
  output logic [CSR_AW-1:0] csrr_addr_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  input  logic              wb_regw_enable_i,
  input  logic [4:0]        wb_regw_addr_i,
  input  logic [XLEN-1:0]   wb_regw_data_i,
  input  logic              ex_jump_flag_i,
  input  logic              ex_ready_i,
  output logic              ex_valid_o,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   inst_addr_o,
  output logic [XLEN-1:0]   reg1_rdata_o,
  output logic [XLEN-1:0]   reg2_rdata_o,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic [XLEN-1:0]   op1_jump_o,
  output logic [XLEN-1:0]   op2_jump_o,
  output logic              regw_enable_o,
  output logic [4:0]        regw_addr_o,
  output logic              csrw_enable_o,
  output logic [CSR_AW-1:0] csrw_addr_o,
  output logic [XLEN-1:0]   csr_rdata_o,
  output logic              is_load_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [31:0]       inst;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   op1j;
    logic [XLEN-1:0]   op2j;
    logic              regw;
    logic [4:0]        rd;
    logic              csrw;
    logic [CSR_AW-1:0] csr_addr;
    logic [XLEN-1:0]   csr_rdata;
    logic              is_load;
    logic              illegal;
  } pipe_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_csr, rs1_use, rs2_use;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, zimm;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic       hazard, xfer;

  pipe_t dec, bubble;
  pipe_t pipe_q, pipe_d;
  logic  valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign opc    = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign is_csr = (opc == OPC_SYSTEM) && (f3 != 3'd0);

  assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_u = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
  assign zimm  = {{(XLEN-5){1'b0}}, inst_i[19:15]};

  // Which source registers the format actually reads. CSR immediate forms
  // (funct3[2]=1) carry a zimm in the rs1 field, so they read nothing.
  always_comb begin
    rs1_use = 1'b0;
    rs2_use = 1'b0;
    unique case (opc)
      OPC_OPIMM, OPC_LOAD, OPC_JALR:      rs1_use = 1'b1;
      OPC_OP, OPC_STORE, OPC_BRANCH: begin
        rs1_use = 1'b1;
        rs2_use = 1'b1;
      end
      OPC_SYSTEM:                         rs1_use = is_csr && !f3[2];
      default: ;
    endcase
  end

  assign regr1_addr_o = rs1_use ? inst_i[19:15] : 5'd0;
  assign regr2_addr_o = rs2_use ? inst_i[24:20] : 5'd0;
  assign csrr_addr_o  = is_csr ? CSR_AW'(inst_i[31:20]) : '0;

  // Address 0 never matches a used source in a harmful way: x0 is never
  // forwarded, so reads of x0 (and unused sources) keep the regfile value.
  assign rs1_data = (FWD_EN && wb_regw_enable_i && wb_regw_addr_i != 5'd0 &&
                     wb_regw_addr_i == regr1_addr_o) ? wb_regw_data_i : reg1_rdata_i;
  assign rs2_data = (FWD_EN && wb_regw_enable_i && wb_regw_addr_i != 5'd0 &&
                     wb_regw_addr_i == regr2_addr_o) ? wb_regw_data_i : reg2_rdata_i;

  always_comb begin
    bubble      = '0;
    bubble.inst = NOP_INST;

    dec      = '0;
    dec.inst = inst_i;
    dec.pc   = inst_addr_i;
    dec.rs1  = rs1_data;
    dec.rs2  = rs2_data;
    unique case (opc)
      OPC_OPIMM:  begin dec.op1 = rs1_data; dec.op2 = imm_i; dec.regw = 1'b1; end
      OPC_OP:     begin dec.op1 = rs1_data; dec.op2 = rs2_data; dec.regw = 1'b1; end
      OPC_LOAD:   begin dec.op1 = rs1_data; dec.op2 = imm_i; dec.regw = 1'b1;
                        dec.is_load = 1'b1; end
      OPC_STORE:  begin dec.op1 = rs1_data; dec.op2 = imm_s; end
      OPC_BRANCH: begin dec.op1 = rs1_data; dec.op2 = rs2_data;
                        dec.op1j = inst_addr_i; dec.op2j = imm_b; end
      OPC_JAL:    begin dec.op1 = inst_addr_i; dec.op2 = XLEN'(4);
                        dec.op1j = inst_addr_i; dec.op2j = imm_j; dec.regw = 1'b1; end
      OPC_JALR:   begin dec.op1 = inst_addr_i; dec.op2 = XLEN'(4);
                        dec.op1j = rs1_data; dec.op2j = imm_i; dec.regw = 1'b1; end
      OPC_LUI:    begin dec.op1 = imm_u; dec.regw = 1'b1; end
      OPC_AUIPC:  begin dec.op1 = inst_addr_i; dec.op2 = imm_u; dec.regw = 1'b1; end
      OPC_SYSTEM: if (is_csr) begin
                    dec.op1       = f3[2] ? zimm : rs1_data;
                    dec.csrw      = 1'b1;
                    dec.csr_addr  = CSR_AW'(inst_i[31:20]);
                    dec.csr_rdata = csr_rdata_i;
                    dec.regw      = 1'b1;
                  end
      OPC_FENCE:  ;
      default:    dec.illegal = 1'b1;
    endcase
    if (inst_i[11:7] == 5'd0) dec.regw = 1'b0;
    dec.rd = dec.regw ? inst_i[11:7] : 5'd0;
  end

  // Load-use: the load in EX has not produced its data yet.
  assign hazard = valid_q && pipe_q.is_load && pipe_q.rd != 5'd0 && inst_valid_i &&
                  (regr1_addr_o == pipe_q.rd || regr2_addr_o == pipe_q.rd);

  assign id_ready_o = ex_jump_flag_i || (!hazard && (!valid_q || ex_ready_i));
  assign xfer       = inst_valid_i && id_ready_o;

  always_comb begin
    valid_d = valid_q;
    pipe_d  = pipe_q;
    cnt_d   = cnt_q;
    if (ex_jump_flag_i) begin
      valid_d = 1'b0;
      pipe_d  = bubble;
    end else if (hazard) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (ex_ready_i) begin
        valid_d = 1'b0;
        pipe_d  = bubble;
      end
    end else if (xfer) begin
      valid_d = 1'b1;
      pipe_d  = dec;
    end else if (ex_ready_i) begin
      valid_d = 1'b0;
      pipe_d  = bubble;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pipe_q  <= bubble;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pipe_q  <= pipe_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign inst_o        = pipe_q.inst;
  assign inst_addr_o   = pipe_q.pc;
  assign reg1_rdata_o  = pipe_q.rs1;
  assign reg2_rdata_o  = pipe_q.rs2;
  assign op1_o         = pipe_q.op1;
  assign op2_o         = pipe_q.op2;
  assign op1_jump_o    = pipe_q.op1j;
  assign op2_jump_o    = pipe_q.op2j;
  assign regw_enable_o = pipe_q.regw;
  assign regw_addr_o   = pipe_q.rd;
  assign csrw_enable_o = pipe_q.csrw;
  assign csrw_addr_o   = pipe_q.csr_addr;
  assign csr_rdata_o   = pipe_q.csr_rdata;
  assign is_load_o     = pipe_q.is_load;
  assign illegal_o     = pipe_q.illegal;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: reset, decode, load-use stall, flush,
// hold under backpressure, forwarding, illegal opcode, CSR decode.
module tb_id_ex_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i;
  logic        inst_valid_i, id_ready_o;
  logic [4:0]  regr1_addr_o, regr2_addr_o;
  logic [31:0] reg1_rdata_i, reg2_rdata_i, csrr_addr_o, csr_rdata_i;
  logic        wb_regw_enable_i;
  logic [4:0]  wb_regw_addr_i;
  logic [31:0] wb_regw_data_i;
  logic        ex_jump_flag_i, ex_ready_i, ex_valid_o;
  logic [31:0] inst_o, inst_addr_o, reg1_rdata_o, reg2_rdata_o;
  logic [31:0] op1_o, op2_o, op1_jump_o, op2_jump_o;
  logic        regw_enable_o, csrw_enable_o, is_load_o, illegal_o;
  logic [4:0]  regw_addr_o;
  logic [31:0] csrw_addr_o, csr_rdata_o;
  logic [15:0] stall_cnt_o;

  logic [31:0] rf [32];
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  assign reg1_rdata_i = rf[regr1_addr_o];
  assign reg2_rdata_i = rf[regr2_addr_o];
  assign csr_rdata_i  = 32'hC5C5_0000;

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .inst_valid_i(inst_valid_i), .id_ready_o(id_ready_o),
    .regr1_addr_o(regr1_addr_o), .regr2_addr_o(regr2_addr_o),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .csrr_addr_o(csrr_addr_o), .csr_rdata_i(csr_rdata_i),
    .wb_regw_enable_i(wb_regw_enable_i), .wb_regw_addr_i(wb_regw_addr_i),
    .wb_regw_data_i(wb_regw_data_i), .ex_jump_flag_i(ex_jump_flag_i),
    .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .reg1_rdata_o(reg1_rdata_o),
    .reg2_rdata_o(reg2_rdata_o), .op1_o(op1_o), .op2_o(op2_o),
    .op1_jump_o(op1_jump_o), .op2_jump_o(op2_jump_o),
    .regw_enable_o(regw_enable_o), .regw_addr_o(regw_addr_o),
    .csrw_enable_o(csrw_enable_o), .csrw_addr_o(csrw_addr_o),
    .csr_rdata_o(csr_rdata_o), .is_load_o(is_load_o), .illegal_o(illegal_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one edge, then let outputs settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    inst_i       = ins;
    inst_addr_i  = pc;
    inst_valid_i = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'd10; rf[2] = 32'h200; rf[3] = 32'h1111;
    rf[5] = 32'h55; rf[7] = 32'h77;
    rst = 1'b1; inst_i = 32'h13; inst_addr_i = '0; inst_valid_i = 1'b0;
    wb_regw_enable_i = 1'b0; wb_regw_addr_i = '0; wb_regw_data_i = '0;
    ex_jump_flag_i = 1'b0; ex_ready_i = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'b0, ex_valid_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h13);
    chk("rst_cnt", {16'b0, stall_cnt_o}, 32'h0);

    // addi x5,x1,-3
    issue(32'hFFD08293, 32'h0);
    chk("addi_rdy", {31'b0, id_ready_o}, 32'h1);
    step();
    chk("addi_valid", {31'b0, ex_valid_o}, 32'h1);
    chk("addi_op1", op1_o, 32'd10);
    chk("addi_op2", op2_o, 32'hFFFFFFFD);
    chk("addi_rd", {27'b0, regw_addr_o}, 32'd5);
    chk("addi_we", {31'b0, regw_enable_o}, 32'h1);

    // lw x5,0(x2) then add x6,x5,x7 -> one stall, one bubble
    issue(32'h00012283, 32'h4);
    step();
    chk("lw_load", {31'b0, is_load_o}, 32'h1);
    chk("lw_op1", op1_o, 32'h200);
    issue(32'h00728333, 32'h8);
    chk("lu_rdy", {31'b0, id_ready_o}, 32'h0);
    step();
    chk("lu_bub_valid", {31'b0, ex_valid_o}, 32'h0);
    chk("lu_bub_inst", inst_o, 32'h13);
    chk("lu_cnt", {16'b0, stall_cnt_o}, 32'd1);
    chk("lu_rdy2", {31'b0, id_ready_o}, 32'h1);
    step();
    chk("add_valid", {31'b0, ex_valid_o}, 32'h1);
    chk("add_inst", inst_o, 32'h00728333);
    chk("add_op2", op2_o, 32'h77);
    chk("add_cnt", {16'b0, stall_cnt_o}, 32'd1);

    // flush with a valid beq pending
    issue(32'h00208463, 32'hC);
    ex_jump_flag_i = 1'b1;
    #1;
    chk("fl_rdy", {31'b0, id_ready_o}, 32'h1);
    step();
    ex_jump_flag_i = 1'b0;
    chk("fl_valid", {31'b0, ex_valid_o}, 32'h0);
    chk("fl_inst", inst_o, 32'h13);

    // jal x1,+0x20 at 0x100, then hold 3 cycles
    issue(32'h020000EF, 32'h100);
    step();
    chk("jal_op1", op1_o, 32'h100);
    ex_ready_i = 1'b0;
    issue(32'hFFD08293, 32'h104);
    for (int c = 0; c < 3; c++) begin
      chk("hold_rdy", {31'b0, id_ready_o}, 32'h0);
      step();
      chk("hold_valid", {31'b0, ex_valid_o}, 32'h1);
      chk("hold_op1j", op1_jump_o, 32'h100);
      chk("hold_op2j", op2_jump_o, 32'h20);
      chk("hold_op2", op2_o, 32'd4);
    end
    ex_ready_i = 1'b1;
    inst_valid_i = 1'b0;
    step();
    chk("drain_valid", {31'b0, ex_valid_o}, 32'h0);

    // add x4,x3,x3 with write-back of x3 in flight
    wb_regw_enable_i = 1'b1; wb_regw_addr_i = 5'd3; wb_regw_data_i = 32'hABCD;
    issue(32'h00318233, 32'h200);
    step();
    wb_regw_enable_i = 1'b0;
    chk("fwd_op1", op1_o, 32'hABCD);
    chk("fwd_op2", op2_o, 32'hABCD);
    chk("fwd_rs1", reg1_rdata_o, 32'hABCD);

    // illegal opcode 7'b1111111 with rd=4
    issue(32'h0000027F, 32'h204);
    step();
    chk("ill_flag", {31'b0, illegal_o}, 32'h1);
    chk("ill_we", {31'b0, regw_enable_o}, 32'h0);
    chk("ill_valid", {31'b0, ex_valid_o}, 32'h1);

    // lui x7,0x12345
    issue(32'h123453B7, 32'h208);
    step();
    chk("lui_op1", op1_o, 32'h12345000);
    chk("lui_op2", op2_o, 32'h0);

    // addi x0,x1,1: rd==0 kills the write
    issue(32'h00108013, 32'h20C);
    step();
    chk("x0_we", {31'b0, regw_enable_o}, 32'h0);

    // csrrw x1,0x305,x2
    issue(32'h305110F3, 32'h210);
    chk("csr_raddr", csrr_addr_o, 32'h305);
    step();
    chk("csr_we", {31'b0, csrw_enable_o}, 32'h1);
    chk("csr_waddr", csrw_addr_o, 32'h305);
    chk("csr_rdata", csr_rdata_o, 32'hC5C5_0000);
    chk("csr_regw", {31'b0, regw_enable_o}, 32'h1);

    // reset during a load-use stall
    issue(32'h00012283, 32'h214);
    step();
    issue(32'h00728333, 32'h218);
    rst = 1'b1;
    step();
    rst = 1'b0;
    inst_valid_i = 1'b0;
    chk("rstst_valid", {31'b0, ex_valid_o}, 32'h0);
    chk("rstst_cnt", {16'b0, stall_cnt_o}, 32'h0);
    chk("rstst_inst", inst_o, 32'h13);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Parametrised RV32I decode stage with a built-in ID/EX pipeline register.
- Sits between the IF/ID register and the EX stage.
- Decodes the instruction and the operand pairs (op1/op2 for the ALU, op1_jump/op2_jump for the branch adder), then registers them behind a valid/ready handshake.
- Adds the following:
  - load-use interlock,
  - write-back forwarding,
  - a jump flush,
  - illegal-instruction flagging,
  - a stall counter.

Parameters:
- XLEN, 32, data and address width.
- CSR_AW, 32, width of the CSR address ports (CSR number is zero-extended).
- NOP_INST, 32'h00000013, instruction injected on flush and reset.
- FWD_EN, 1, enables write-back forwarding onto the rs1/rs2 data.
- CNT_W, 16, width of the stall counter (saturating).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- inst_i  in  32  instruction from the IF/ID register.
- inst_addr_i  in  XLEN  PC of inst_i.
- inst_valid_i  in  1  inst_i is valid.
- id_ready_o  out  1  stage accepts inst_i this cycle.
- regr1_addr_o / regr2_addr_o  out  5  register-file read addresses (combinational).
- reg1_rdata_i / reg2_rdata_i  in  XLEN  register-file read data (same cycle).
- csrr_addr_o  out  CSR_AW  CSR read address (combinational).
- csr_rdata_i  in  XLEN  CSR read data.
- wb_regw_enable_i  in  1  write-back write enable, used for forwarding.
- wb_regw_addr_i  in  5  write-back destination register.
- wb_regw_data_i  in  XLEN  write-back data.
- ex_jump_flag_i  in  1  taken jump/branch resolved in EX; triggers the flush.
- ex_ready_i  in  1  EX accepts the registered outputs.
- ex_valid_o  out  1  registered outputs are valid.
- inst_o  out  32  registered instruction.
- inst_addr_o  out  XLEN  registered PC.
- reg1_rdata_o / reg2_rdata_o  out  XLEN  registered, forwarded rs data.
- op1_o / op2_o  out  XLEN  registered ALU operands.
- op1_jump_o / op2_jump_o  out  XLEN  registered jump-target operands.
- regw_enable_o  out  1  registered register-file write enable.
- regw_addr_o  out  5  registered destination register.
- csrw_enable_o  out  1  registered CSR write enable.
- csrw_addr_o  out  CSR_AW  registered CSR address.
- csr_rdata_o  out  XLEN  registered CSR read data.
- is_load_o  out  1  registered instruction is a load.
- illegal_o  out  1  registered instruction is illegal.
- stall_cnt_o  out  CNT_W  count of load-use stall cycles.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - ex_valid_o=0, inst_o=NOP_INST.
  - Every other registered output is 0, including stall_cnt_o.
  - rst wins over every other event, including mid-stall and mid-flush.
- Decode (combinational from inst_i):
  - I-ALU: op1=rs1, op2=sext(imm_i), regw=1.
  - R-type: op1=rs1, op2=rs2, regw=1.
  - LOAD: op1=rs1, op2=sext(imm_i), regw=1, is_load=1.
  - STORE: op1=rs1, op2=sext(imm_s), regw=0.
  - BRANCH: op1=rs1, op2=rs2, op1_jump=pc, op2_jump=sext(imm_b), regw=0.
  - JAL: op1=pc, op2=4, op1_jump=pc, op2_jump=sext(imm_j), regw=1.
  - JALR: op1=pc, op2=4, op1_jump=rs1, op2_jump=sext(imm_i), regw=1.
  - LUI: op1=imm_u, op2=0, regw=1.
  - AUIPC: op1=pc, op2=imm_u, regw=1.
  - SYSTEM with funct3!=0: csrr_addr=csrw_addr=inst[31:20], csrw_enable=1, regw=1.
  - SYSTEM with funct3==0, and FENCE: all enables 0.
  - Any other opcode: illegal=1, all enables 0, all operands 0.
  - Unused operands are 0.
  - regr1/regr2 addresses are 0 for formats that do not read rs1/rs2.
  - regw forced to 0 when rd==0.
- Forwarding (FWD_EN=1): when wb_regw_enable_i is set, wb_regw_addr_i!=0 and it equals rs1 (or rs2), wb_regw_data_i replaces reg1_rdata_i (or reg2_rdata_i) before operand selection.
- Load-use hazard:
  - Condition: ex_valid_o & is_load_o & regw_addr_o!=0, and regw_addr_o matches an rs actually read by inst_i while inst_valid_i=1.
  - id_ready_o=0 during the hazard.
  - If ex_ready_i=1 in that cycle, the output register loads a bubble (ex_valid_o=0, inst_o=NOP_INST, enables 0).
  - stall_cnt_o increments once per hazard cycle and saturates at all-ones.
- Handshake:
  - id_ready_o = !hazard & (!ex_valid_o | ex_ready_i).
  - Transfer occurs when inst_valid_i & id_ready_o; the output register loads at the next edge with ex_valid_o=1.
  - If ex_ready_i=1 and no transfer occurs, ex_valid_o becomes 0.
  - If ex_valid_o=1 and ex_ready_i=0, all outputs hold stable.
  - Latency: 1 cycle from input transfer to output.
- Flush (ex_jump_flag_i=1):
  - The next edge loads a bubble regardless of inst_valid_i, ex_ready_i or hazard; the incoming instruction is dropped.
  - id_ready_o=1 during the flush cycle so IF drains.
  - Flush takes priority over stall and hold; the stall counter does not increment in that cycle.

Test Plan:
- rst=1 for 2 cycles, then 0 -> ex_valid_o=0, inst_o=32'h00000013, stall_cnt_o=0.
- addi x5,x1,-3 with x1=10, ex_ready_i=1 -> next cycle: ex_valid_o=1, op1_o=10, op2_o=32'hFFFFFFFD, regw_addr_o=5, regw_enable_o=1.
- lw x5,0(x2) followed by add x6,x5,x7 -> id_ready_o=0 for 1 cycle, one bubble, stall_cnt_o=1, add issued the following cycle.
- ex_jump_flag_i=1 with a valid beq input -> next cycle: ex_valid_o=0, inst_o=NOP_INST, beq dropped.
- ex_ready_i=0 for 3 cycles with jal at pc=0x100, imm=0x20 -> outputs held (op1_jump_o=0x100, op2_jump_o=0x20, op2_o=4), id_ready_o=0.
- Write-back writes x3=0xABCD while decoding add x4,x3,x3 with stale reg data -> op1_o=op2_o=0xABCD. Separately, opcode 7'b1111111 -> illegal_o=1 and regw_enable_o=0.
